// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// Optional memory handshake: MEM_HANDSHAKE_EN.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP,
    C_R,
    C_IARITH,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_ECALL
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_ALU = 2'b01;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       inst_done;
    logic       is_halted;
  } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode to instruction-class mapping.
// Unknown opcodes fall back to the NOP class.
module mc_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output class_t     inst_class
);

  always_comb begin
    inst_class = C_NOP;
    unique case (1'b1)
      (opcode == OP_R):      inst_class = C_R;
      (opcode == OP_IARITH): inst_class = C_IARITH;
      (opcode == OP_LOAD):   inst_class = C_LOAD;
      (opcode == OP_STORE):  inst_class = C_STORE;
      (opcode == OP_BRANCH): inst_class = C_BRANCH;
      (opcode == OP_JAL):    inst_class = C_JAL;
      (opcode == OP_JALR):   inst_class = C_JALR;
      (opcode == OP_ECALL):  inst_class = C_ECALL;
      default:               inst_class = C_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: IF/ID/EX/MEM/WB plus sticky HALT.
// MEM_HANDSHAKE_EN enables stalling IF/MEM on mem_ready.
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       ecall_halt,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       inst_done,
  output logic       is_halted
);

  state_t state_q, state_d;
  class_t class_q, class_dec;
  ctrl_t  c, o;
  logic   mem_rdy;

`ifdef MEM_HANDSHAKE_EN
  assign mem_rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy = 1'b1;
`endif

  mc_opcode_decode u_dec (
    .opcode     (opcode),
    .inst_class (class_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      class_q <= C_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID)
        class_q <= class_dec;
    end
  end

  always_comb begin
    state_d = state_q;
    c       = '0;
    unique case (state_q)
      S_IF: begin
        c.mem_read = 1'b1;
        c.ir_write = mem_rdy;
        if (mem_rdy)
          state_d = S_ID;
      end
      S_ID: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        state_d     = S_EX;
      end
      S_EX: begin
        unique case (class_q)
          C_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALU_FUNCT;
            state_d     = S_WB;
          end
          C_IARITH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_FUNCT;
            state_d     = S_WB;
          end
          C_LOAD, C_STORE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            state_d     = S_MEM;
          end
          C_JALR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            state_d     = S_WB;
          end
          C_JAL: state_d = S_WB;
          C_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALU_BR;
            c.pc_write  = 1'b1;
            c.pc_source = alu_bcond ? PCSRC_ALU : PCSRC_PC4;
            c.inst_done = 1'b1;
            state_d     = S_IF;
          end
          C_ECALL: begin
            c.inst_done = 1'b1;
            c.pc_write  = ~ecall_halt;
            state_d     = ecall_halt ? S_HALT : S_IF;
          end
          default: begin
            c.pc_write  = 1'b1;
            c.inst_done = 1'b1;
            state_d     = S_IF;
          end
        endcase
      end
      S_MEM: begin
        c.i_or_d = 1'b1;
        if (class_q == C_LOAD) begin
          c.mem_read = 1'b1;
          if (mem_rdy)
            state_d = S_WB;
        end else if (class_q == C_STORE) begin
          c.mem_write = 1'b1;
          if (mem_rdy) begin
            c.pc_write  = 1'b1;
            c.inst_done = 1'b1;
            state_d     = S_IF;
          end
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        c.reg_write = 1'b1;
        c.pc_write  = 1'b1;
        c.inst_done = 1'b1;
        state_d     = S_IF;
        if (class_q == C_LOAD)
          c.mem_to_reg = 1'b1;
        if (class_q == C_JAL || class_q == C_JALR) begin
          c.pc_to_reg = 1'b1;
          c.pc_source = PCSRC_ALU;
        end
      end
      S_HALT: c.is_halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // Reset masks every strobe immediately, aborting any access in flight.
  assign o = reset ? '0 : c;

  assign pc_write   = o.pc_write;
  assign pc_source  = o.pc_source;
  assign i_or_d     = o.i_or_d;
  assign mem_read   = o.mem_read;
  assign mem_write  = o.mem_write;
  assign ir_write   = o.ir_write;
  assign reg_write  = o.reg_write;
  assign mem_to_reg = o.mem_to_reg;
  assign pc_to_reg  = o.pc_to_reg;
  assign alu_src_a  = o.alu_src_a;
  assign alu_src_b  = o.alu_src_b;
  assign alu_op     = o.alu_op;
  assign inst_done  = o.inst_done;
  assign is_halted  = o.is_halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; per-cycle output vectors.
// Wait-state steps depend on MEM_HANDSHAKE_EN.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       ecall_halt;
  logic       alu_bcond;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       pc_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       inst_done;
  logic       is_halted;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] EC = 7'b1110011;
  localparam logic [6:0] UD = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .ecall_halt (ecall_halt),
    .alu_bcond  (alu_bcond),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .pc_to_reg  (pc_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .inst_done  (inst_done),
    .is_halted  (is_halted)
  );

  logic [16:0] obs;
  assign obs = {pc_write, pc_source, i_or_d, mem_read, mem_write,
                ir_write, reg_write, mem_to_reg, pc_to_reg,
                alu_src_a, alu_src_b, alu_op, inst_done, is_halted};

  function automatic logic [16:0] v(
    input logic pw, input logic [1:0] ps,
    input logic iod, input logic mr, input logic mw,
    input logic irw, input logic rw, input logic m2r,
    input logic p2r, input logic a, input logic [1:0] b,
    input logic [1:0] op, input logic dn, input logic h);
    return {pw, ps, iod, mr, mw, irw, rw, m2r, p2r, a, b, op, dn, h};
  endfunction

  logic [16:0] e_if, e_ifw, e_id, e_ex_r, e_ex_i, e_ex_ls, e_ex_j;
  logic [16:0] e_br_t, e_br_n, e_nop, e_ec_h, e_mld, e_mstw, e_mst;
  logic [16:0] e_wb, e_wb_ld, e_wb_j, e_halt, e_zero;

  task automatic check(input logic [16:0] e, input string tag);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, e);
    end
  endtask

  task automatic cyc(input logic [6:0] op, input logic rdy,
                     input logic bc, input logic eh,
                     input logic [16:0] e, input string tag);
    opcode     = op;
    mem_ready  = rdy;
    alu_bcond  = bc;
    ecall_halt = eh;
    #2;
    check(e, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    e_if    = v(0,2'd0,0,1,0,1,0,0,0,0,2'd0,2'd0,0,0);
    e_ifw   = v(0,2'd0,0,1,0,0,0,0,0,0,2'd0,2'd0,0,0);
    e_id    = v(0,2'd0,0,0,0,0,0,0,0,0,2'd2,2'd0,0,0);
    e_ex_r  = v(0,2'd0,0,0,0,0,0,0,0,1,2'd0,2'd2,0,0);
    e_ex_i  = v(0,2'd0,0,0,0,0,0,0,0,1,2'd2,2'd2,0,0);
    e_ex_ls = v(0,2'd0,0,0,0,0,0,0,0,1,2'd2,2'd0,0,0);
    e_ex_j  = v(0,2'd0,0,0,0,0,0,0,0,0,2'd0,2'd0,0,0);
    e_br_t  = v(1,2'd1,0,0,0,0,0,0,0,1,2'd0,2'd1,1,0);
    e_br_n  = v(1,2'd0,0,0,0,0,0,0,0,1,2'd0,2'd1,1,0);
    e_nop   = v(1,2'd0,0,0,0,0,0,0,0,0,2'd0,2'd0,1,0);
    e_ec_h  = v(0,2'd0,0,0,0,0,0,0,0,0,2'd0,2'd0,1,0);
    e_mld   = v(0,2'd0,1,1,0,0,0,0,0,0,2'd0,2'd0,0,0);
    e_mstw  = v(0,2'd0,1,0,1,0,0,0,0,0,2'd0,2'd0,0,0);
    e_mst   = v(1,2'd0,1,0,1,0,0,0,0,0,2'd0,2'd0,1,0);
    e_wb    = v(1,2'd0,0,0,0,0,1,0,0,0,2'd0,2'd0,1,0);
    e_wb_ld = v(1,2'd0,0,0,0,0,1,1,0,0,2'd0,2'd0,1,0);
    e_wb_j  = v(1,2'd1,0,0,0,0,1,0,1,0,2'd0,2'd0,1,0);
    e_halt  = v(0,2'd0,0,0,0,0,0,0,0,0,2'd0,2'd0,0,1);
    e_zero  = '0;

    reset = 1'b1; opcode = R; mem_ready = 1'b1;
    alu_bcond = 1'b1; ecall_halt = 1'b1;
    #1;
    check(e_zero, "reset_outputs");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // ADD
    cyc(R, 1, 0, 0, e_if,   "add_if");
    cyc(R, 1, 0, 0, e_id,   "add_id");
    cyc(R, 1, 0, 0, e_ex_r, "add_ex");
    cyc(R, 1, 0, 0, e_wb,   "add_wb");

    // ADDI with a fetch wait
`ifdef MEM_HANDSHAKE_EN
    cyc(IA, 0, 0, 0, e_ifw, "addi_if_wait");
`else
    cyc(IA, 0, 0, 0, e_if,  "addi_if_ignored_ready");
`endif
`ifdef MEM_HANDSHAKE_EN
    cyc(IA, 1, 0, 0, e_if,   "addi_if");
`endif
    cyc(IA, 1, 0, 0, e_id,   "addi_id");
    cyc(IA, 1, 0, 0, e_ex_i, "addi_ex");
    cyc(IA, 1, 0, 0, e_wb,   "addi_wb");

    // LW with two MEM wait cycles
    cyc(LD, 1, 0, 0, e_if,    "lw_if");
    cyc(LD, 1, 0, 0, e_id,    "lw_id");
    cyc(LD, 1, 0, 0, e_ex_ls, "lw_ex");
    cyc(LD, 0, 0, 0, e_mld,   "lw_mem0");
`ifdef MEM_HANDSHAKE_EN
    cyc(LD, 0, 0, 0, e_mld,   "lw_mem_wait");
    cyc(LD, 1, 0, 0, e_mld,   "lw_mem_done");
`endif
    cyc(LD, 1, 0, 0, e_wb_ld, "lw_wb");

    // BEQ taken then not taken
    cyc(BR, 1, 1, 0, e_if,   "beq_t_if");
    cyc(BR, 1, 1, 0, e_id,   "beq_t_id");
    cyc(BR, 1, 1, 0, e_br_t, "beq_t_ex");
    cyc(BR, 1, 0, 0, e_if,   "beq_n_if");
    cyc(BR, 1, 0, 0, e_id,   "beq_n_id");
    cyc(BR, 1, 0, 0, e_br_n, "beq_n_ex");

    // JAL, JALR
    cyc(JL, 1, 0, 0, e_if,    "jal_if");
    cyc(JL, 1, 0, 0, e_id,    "jal_id");
    cyc(JL, 1, 0, 0, e_ex_j,  "jal_ex");
    cyc(JL, 1, 0, 0, e_wb_j,  "jal_wb");
    cyc(JR, 1, 0, 0, e_if,    "jalr_if");
    cyc(JR, 1, 0, 0, e_id,    "jalr_id");
    cyc(JR, 1, 0, 0, e_ex_ls, "jalr_ex");
    cyc(JR, 1, 0, 0, e_wb_j,  "jalr_wb");

    // SW with one wait, then completion
    cyc(ST, 1, 0, 0, e_if,    "sw_if");
    cyc(ST, 1, 0, 0, e_id,    "sw_id");
    cyc(ST, 1, 0, 0, e_ex_ls, "sw_ex");
`ifdef MEM_HANDSHAKE_EN
    cyc(ST, 0, 0, 0, e_mstw,  "sw_mem_wait");
`endif
    cyc(ST, 1, 0, 0, e_mst,   "sw_mem");

    // ECALL without halt
    cyc(EC, 1, 0, 0, e_if,  "ecall_nh_if");
    cyc(EC, 1, 0, 0, e_id,  "ecall_nh_id");
    cyc(EC, 1, 0, 0, e_nop, "ecall_nh_ex");

    // SW aborted by reset in MEM
    cyc(ST, 1, 0, 0, e_if,    "swr_if");
    cyc(ST, 1, 0, 0, e_id,    "swr_id");
    cyc(ST, 1, 0, 0, e_ex_ls, "swr_ex");
    opcode = ST; mem_ready = 1'b0;
    #2;
`ifdef MEM_HANDSHAKE_EN
    check(e_mstw, "swr_mem_before_reset");
`else
    check(e_mst,  "swr_mem_before_reset");
`endif
    reset = 1'b1;
    #1;
    check(e_zero, "swr_reset_async");
    @(posedge clk); #1;
    check(e_zero, "swr_reset_held");
    reset = 1'b0;

    // Undefined opcode behaves as NOP
    cyc(UD, 1, 0, 0, e_if,  "ud_if");
    cyc(UD, 1, 0, 0, e_id,  "ud_id");
    cyc(UD, 1, 0, 0, e_nop, "ud_ex");

    // Terminating ECALL then sticky halt
    cyc(EC, 1, 0, 1, e_if,   "ecall_h_if");
    cyc(EC, 1, 0, 1, e_id,   "ecall_h_id");
    cyc(EC, 1, 0, 1, e_ec_h, "ecall_h_ex");
    for (int i = 0; i < 100; i++)
      cyc(R, 1'(i % 2), 1'(i % 3 == 0), 1'(i % 5 == 0),
          e_halt, "halt_hold");

    reset = 1'b1;
    #1;
    check(e_zero, "halt_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(R, 1, 0, 0, e_if, "post_halt_if");
    cyc(R, 1, 0, 0, e_id, "post_halt_id");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
